// File: rtl/simon_pkg.sv
// Shared Simon32/64 types, constants and round-key FSM states.
// Build option: DECRYPT_ORDER_EN adds the FILL/DRAIN states.
package simon_pkg;

    typedef logic [15:0] word_t;
    typedef word_t [3:0] key_t;

    localparam int NUM_ROUNDS_DEFAULT = 32;

    // z0 constant sequence, first bit in the MSB
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND
`ifdef DECRYPT_ORDER_EN
        ,
        FILL,
        DRAIN
`endif
    } rkg_state_t;

    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (16 - n));
    endfunction

endpackage

// File: rtl/round_key_gen_if.sv
// Key-load and round-key handshake bundle for round_key_gen.
// Build option: DECRYPT_ORDER_EN adds the decrypt request bit.
interface round_key_gen_if;
    import simon_pkg::*;

    key_t       key_in;
    logic       key_valid;
    logic       key_ready;
    word_t      rk_out;
    logic [4:0] rk_round;
    logic       rk_valid;
    logic       rk_ready;
    logic       done;
`ifdef DECRYPT_ORDER_EN
    logic       decrypt;
`endif

    modport master (
        output key_in, key_valid, rk_ready,
`ifdef DECRYPT_ORDER_EN
        decrypt,
`endif
        input key_ready, rk_out, rk_round, rk_valid, done
    );

    modport slave (
        input key_in, key_valid, rk_ready,
`ifdef DECRYPT_ORDER_EN
        decrypt,
`endif
        output key_ready, rk_out, rk_round, rk_valid, done
    );

endinterface

// File: rtl/key_schedule.sv
// Simon32/64 key-schedule step: k(i+4) from k(i)..k(i+3).
// Purely combinational; round_counter selects the z0 bit.
module key_schedule
    import simon_pkg::*;
(
    input  key_t       input_key,
    input  logic [4:0] round_counter,
    output word_t      next
);

    word_t t0;
    word_t t1;
    logic  zb;

    // one schedule step, constant c = 0xFFFC folded as ~k ^ 3
    always_comb begin
        t0   = ror(input_key[3], 3) ^ input_key[1];
        t1   = t0 ^ ror(t0, 1);
        zb   = Z0[6'd61 - {1'b0, round_counter}];
        next = ~input_key[0] ^ t1 ^ {15'd0, zb} ^ 16'h0003;
    end

endmodule

// File: rtl/round_key_gen.sv
// Streams Simon32/64 round keys from a loaded master key.
// Build option: DECRYPT_ORDER_EN buffers keys and emits them reversed.
module round_key_gen
    import simon_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    round_key_gen_if.slave  bus
);

    localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

    rkg_state_t state;
    key_t       w;
    logic [4:0] round;
    word_t      rk_q;
    logic       kr_q;
    logic       rv_q;
    logic       done_q;
    word_t      nxt;
    logic       accept;
    logic       hs;

`ifdef DECRYPT_ORDER_EN
    word_t      arr [NUM_ROUNDS];
`endif

    assign accept = bus.key_valid & kr_q;
    assign hs     = rv_q & bus.rk_ready;

    assign bus.key_ready = kr_q;
    assign bus.rk_valid  = rv_q;
    assign bus.rk_out    = rk_q;
    assign bus.rk_round  = round;
    assign bus.done      = done_q;

    key_schedule u_ks (
        .input_key     (w),
        .round_counter (round),
        .next          (nxt)
    );

    // sequencing FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            kr_q   <= 1'b0;
            rv_q   <= 1'b0;
            rk_q   <= '0;
            round  <= '0;
            done_q <= 1'b0;
            w      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    kr_q <= 1'b1;
                    if (accept) begin
                        kr_q  <= 1'b0;
                        w     <= bus.key_in;
                        round <= '0;
                        rk_q  <= bus.key_in[0];
`ifdef DECRYPT_ORDER_EN
                        if (bus.decrypt) begin
                            state <= FILL;
                        end else begin
                            state <= EXPAND;
                            rv_q  <= 1'b1;
                        end
`else
                        state <= EXPAND;
                        rv_q  <= 1'b1;
`endif
                    end
                end
                EXPAND: begin
                    if (hs) begin
                        if (round == LAST) begin
                            state  <= IDLE;
                            rv_q   <= 1'b0;
                            done_q <= 1'b1;
                            kr_q   <= 1'b1;
                        end else begin
                            w     <= {nxt, w[3:1]};
                            round <= round + 5'd1;
                            rk_q  <= w[1];
                        end
                    end
                end
`ifdef DECRYPT_ORDER_EN
                FILL: begin
                    arr[round] <= w[0];
                    w          <= {nxt, w[3:1]};
                    if (round == LAST) begin
                        state <= DRAIN;
                        rv_q  <= 1'b1;
                        rk_q  <= w[0];
                    end else begin
                        round <= round + 5'd1;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (round == 5'd0) begin
                            state  <= IDLE;
                            rv_q   <= 1'b0;
                            done_q <= 1'b1;
                            kr_q   <= 1'b1;
                        end else begin
                            round <= round - 5'd1;
                            rk_q  <= arr[round - 5'd1];
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_gen.sv
// Directed self-checking bench for round_key_gen.
// Build option: DECRYPT_ORDER_EN enables the reverse-order scenario.
module tb_round_key_gen;
    import simon_pkg::*;

    typedef word_t gold_t [32];

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    round_key_gen_if bus ();

    round_key_gen #(.NUM_ROUNDS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam key_t KA = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
    localparam key_t KB = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678};

    gold_t ga;
    gold_t gb;

    // reference key expansion written from the published algorithm
    function automatic gold_t golden(input key_t key);
        string z;
        word_t k [36];
        word_t t;
        gold_t g;
        z = "11111010001001010110000111001101111101000100101011000011100110";
        for (int i = 0; i < 4; i++) k[i] = key[i];
        for (int i = 0; i < 28; i++) begin
            t = {k[i+3][2:0], k[i+3][15:3]} ^ k[i+1];
            t = t ^ {t[0], t[15:1]};
            k[i+4] = ~k[i] ^ t ^ 16'h0003;
            if (z[i] == 8'h31) k[i+4] = k[i+4] ^ 16'h0001;
        end
        for (int i = 0; i < 32; i++) g[i] = k[i];
        return g;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // present a key and wait (bounded) until it is taken
    task automatic load_key(input key_t k);
        int n;
        n = 0;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        while (!bus.key_ready && n < 10) begin
            tick();
            n++;
        end
        if (!bus.key_ready) begin
            checks++;
            errors++;
            $display("FAIL load_timeout key_ready=%b want 1", bus.key_ready);
        end
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.key_ready, bus.rk_valid, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b%b%b want 000",
                     bus.key_ready, bus.rk_valid, bus.done);
        end
        checks++;
        if (bus.rk_out !== 16'h0000 || bus.rk_round !== 5'd0) begin
            errors++;
            $display("FAIL reset_rk got=%h/%0d want 0000/0",
                     bus.rk_out, bus.rk_round);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release key_ready=%b want 1", bus.key_ready);
        end
    endtask

    task automatic test_encrypt;
        word_t hand [5];
        hand = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
        bus.rk_ready = 1'b1;
        load_key(KA);
        for (int i = 0; i < 32; i++) begin
            if (i < 5) begin
                checks++;
                if (bus.rk_out !== hand[i]) begin
                    errors++;
                    $display("FAIL enc_vector r%0d got=%h want %h",
                             i, bus.rk_out, hand[i]);
                end
            end
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_out !== ga[i] ||
                bus.rk_round !== 5'(i) || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL enc_key r%0d got=%b %h %0d want 1 %h %0d",
                         i, bus.rk_valid, bus.rk_out, bus.rk_round, ga[i], i);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.key_ready !== 1'b1 ||
            bus.rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL enc_done got d=%b kr=%b v=%b want 1 1 0",
                     bus.done, bus.key_ready, bus.rk_valid);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL enc_done_pulse done=%b want 0", bus.done);
        end
    endtask

    task automatic test_backpressure;
        int  idx;
        int  stalls;
        int  cyc;
        logic rdy;
        idx    = 0;
        stalls = 0;
        cyc    = 0;
        bus.rk_ready = 1'b1;
        load_key(KA);
        while (idx < 32 && cyc < 100) begin
            rdy = !(idx == 5 && stalls < 2);
            bus.rk_ready = rdy;
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_out !== ga[idx] ||
                bus.rk_round !== 5'(idx)) begin
                errors++;
                $display("FAIL bp_key r%0d got=%b %h %0d want 1 %h %0d",
                         idx, bus.rk_valid, bus.rk_out, bus.rk_round,
                         ga[idx], idx);
            end
            if (!rdy) stalls++;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        bus.rk_ready = 1'b1;
        checks++;
        if (bus.done !== 1'b1 || idx != 32) begin
            errors++;
            $display("FAIL bp_done done=%b idx=%0d want 1 32", bus.done, idx);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bus.rk_ready = 1'b1;
        load_key(KA);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.rk_round !== 5'd10 || bus.rk_out !== ga[10]) begin
            errors++;
            $display("FAIL rstmid_pre got=%0d %h want 10 %h",
                     bus.rk_round, bus.rk_out, ga[10]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort got v=%b d=%b want 0 0",
                     bus.rk_valid, bus.done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.key_ready !== 1'b1 || bus.done !== 1'b0 ||
            bus.rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got kr=%b d=%b v=%b want 1 0 0",
                     bus.key_ready, bus.done, bus.rk_valid);
        end
        load_key(KB);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_out !== gb[i] ||
                bus.rk_round !== 5'(i)) begin
                errors++;
                $display("FAIL rstmid_key r%0d got=%b %h %0d want 1 %h %0d",
                         i, bus.rk_valid, bus.rk_out, bus.rk_round, gb[i], i);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done done=%b want 1", bus.done);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        bus.rk_ready = 1'b1;
        load_key(KA);
        bus.key_in    = KB;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.rk_out !== ga[i] || bus.rk_round !== 5'(i) ||
                bus.key_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first r%0d got=%h %0d kr=%b want %h %0d 0",
                         i, bus.rk_out, bus.rk_round, bus.key_ready, ga[i], i);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got d=%b kr=%b want 1 1",
                     bus.done, bus.key_ready);
        end
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_round !== 5'd0 ||
            bus.rk_out !== KB[0] || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got=%b %0d %h d=%b want 1 0 %h 0",
                     bus.rk_valid, bus.rk_round, bus.rk_out, bus.done, KB[0]);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.rk_out !== gb[i] || bus.rk_round !== 5'(i)) begin
                errors++;
                $display("FAIL b2b_key r%0d got=%h %0d want %h %0d",
                         i, bus.rk_out, bus.rk_round, gb[i], i);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2 done=%b want 1", bus.done);
        end
        tick();
    endtask

`ifdef DECRYPT_ORDER_EN
    task automatic test_decrypt;
        bus.rk_ready = 1'b1;
        bus.decrypt  = 1'b1;
        load_key(KA);
        bus.decrypt  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.rk_valid !== 1'b0) begin
                errors++;
                $display("FAIL dec_fill c%0d rk_valid=%b want 0",
                         i, bus.rk_valid);
            end
            tick();
        end
        for (int i = 31; i >= 0; i--) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_out !== ga[i] ||
                bus.rk_round !== 5'(i)) begin
                errors++;
                $display("FAIL dec_key r%0d got=%b %h %0d want 1 %h %0d",
                         i, bus.rk_valid, bus.rk_out, bus.rk_round, ga[i], i);
            end
            if (i == 0) begin
                checks++;
                if (bus.rk_out !== 16'h0100) begin
                    errors++;
                    $display("FAIL dec_last got=%h want 0100", bus.rk_out);
                end
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL dec_done got d=%b kr=%b want 1 1",
                     bus.done, bus.key_ready);
        end
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
`ifdef DECRYPT_ORDER_EN
        bus.decrypt   = 1'b0;
`endif
        ga = golden(KA);
        gb = golden(KB);
        test_reset();
        test_encrypt();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DECRYPT_ORDER_EN
        test_decrypt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
